// File: rtl/scope_acq.sv
// Acquisition core with a byte-wide host command port, a per-channel trigger
// matcher and a circular sample buffer with pre-/post-trigger capture.
module scope_acq #(
  parameter int NSIG  = 8,
  parameter int NSAMP = 3,
  parameter int NTIME = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSIG-1:0] sig,
  input  logic            select,
  input  logic [7:0]      dout,
  input  logic            drequest,
  output logic [7:0]      din
);
  localparam int NBYTES = (NSIG + NTIME + 7) / 8;
  localparam int NBITS  = 8 * NBYTES;
  localparam int DEPTH  = 1 << NSAMP;
  localparam int RBYTES = DEPTH * NBYTES;
  localparam int RW     = $clog2(RBYTES + 1);
  localparam logic [NTIME-1:0] TMAX = '1;

  typedef enum logic [1:0] {ARMED, POST, DONE} acq_t;
  acq_t state, state_nx;

  logic              in_xact;
  logic [7:0]        cmd;
  logic [RW-1:0]     rd_cnt;
  logic              restart;
  logic              src_cnt;
  logic [NSAMP-1:0]  npost;
  logic [3*NSIG-1:0] trig_conf;

  logic [NSIG-1:0]   tcount, prev, cur;
  logic [NTIME-1:0]  tcnt;
  logic              first;
  logic [NSAMP:0]    wcount;
  logic [NSAMP-1:0]  wptr, left;
  logic [NBITS-1:0]  mem [DEPTH];
  logic              ready, triggered, done, fire, wr, hit;
  logic [7:0]        status, rd_byte, cmd_resp;

  assign cur       = src_cnt ? tcount : sig;
  assign ready     = int'(wcount) + int'(npost) >= DEPTH;
  assign triggered = state != ARMED;
  assign done      = state == DONE;
  assign status    = {5'b0, done, triggered, ready};
  // readiness is judged including the sample written this cycle, so the
  // trigger sample itself completes the pre-trigger window
  assign fire = (state == ARMED) && hit && (int'(wcount) + int'(npost) + 1 >= DEPTH);
  assign wr   = !restart && (state != DONE) && (first || cur != prev || tcnt == TMAX || fire);

  always_comb begin
    logic any_en, all_ok;
    any_en = 1'b0;
    all_ok = 1'b1;
    for (int c = 0; c < NSIG; c++) begin
      if (trig_conf[3*c+1]) begin
        any_en = 1'b1;
        if (cur[c] != trig_conf[3*c]) all_ok = 1'b0;
        if (trig_conf[3*c+2] && prev[c] == trig_conf[3*c]) all_ok = 1'b0;
      end
    end
    hit = any_en && all_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARMED;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARMED:   if (fire) state_nx = (npost == '0) ? DONE : POST;
      POST:    if (wr && left == NSAMP'(1)) state_nx = DONE;
      default: ;
    endcase
    if (restart) state_nx = ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount <= '0;
      prev   <= '0;
      tcnt   <= '0;
      first  <= 1'b1;
      wcount <= '0;
      wptr   <= '0;
      left   <= '0;
    end else if (restart) begin
      tcount <= '0;
      prev   <= '0;
      tcnt   <= '0;
      first  <= 1'b1;
      wcount <= '0;
      wptr   <= '0;
      left   <= '0;
    end else begin
      tcount <= tcount + 1'b1;
      prev   <= cur;
      first  <= 1'b0;
      if (wr) begin
        tcnt <= NTIME'(1);
        wptr <= wptr + 1'b1;
        if (int'(wcount) < DEPTH) wcount <= wcount + 1'b1;
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
      end
      if (fire)                     left <= npost;
      else if (wr && state == POST) left <= left - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= NBITS'({tcnt, cur});
  end

  // once the buffer has wrapped, the oldest sample sits at the write pointer
  always_comb begin
    int s, b;
    logic [NSAMP-1:0] addr;
    logic [NBITS-1:0] word;
    s       = int'(rd_cnt) / NBYTES;
    b       = int'(rd_cnt) % NBYTES;
    addr    = (wcount[NSAMP] ? wptr : '0) + NSAMP'(s);
    word    = mem[addr] >> (8 * b);
    rd_byte = 8'h00;
    if (s < (wcount[NSAMP] ? DEPTH : int'(wcount))) rd_byte = word[7:0];
  end

  always_comb begin
    cmd_resp = 8'h00;
    case (dout)
      8'h11:   cmd_resp = 8'h53;
      8'h12:   cmd_resp = {4'(NTIME), 4'(NSIG)};
      8'h13:   cmd_resp = 8'(NSAMP);
      8'h14:   cmd_resp = status;
      8'h16:   cmd_resp = rd_byte;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din       <= 8'h00;
      in_xact   <= 1'b0;
      cmd       <= 8'h00;
      rd_cnt    <= '0;
      restart   <= 1'b0;
      src_cnt   <= 1'b0;
      npost     <= '0;
      trig_conf <= '0;
    end else begin
      restart <= 1'b0;
      if (!select) begin
        in_xact <= 1'b0;
        cmd     <= 8'h00;
        rd_cnt  <= '0;
      end else if (drequest) begin
        if (!in_xact) begin
          in_xact <= 1'b1;
          cmd     <= dout;
          rd_cnt  <= RW'(1);
          din     <= cmd_resp;
          if (dout[7:4] == 4'h3)             src_cnt <= dout[0];
          if (dout[7:4] == 4'h2 && dout[3])  restart <= 1'b1;
        end else if (cmd == 8'h14) begin
          din <= status;
        end else if (cmd == 8'h16) begin
          din <= rd_byte;
          if (int'(rd_cnt) < RBYTES) rd_cnt <= rd_cnt + 1'b1;
        end else begin
          // argument commands take exactly one byte, then fall silent
          din <= 8'h00;
          cmd <= 8'h00;
          if (cmd == 8'h15)
            npost <= (dout > 8'(DEPTH - 1)) ? NSAMP'(DEPTH - 1) : NSAMP'(dout);
          for (int c = 0; c < NSIG; c++)
            if (cmd == (8'h40 | 8'(c))) trig_conf[3*c +: 3] <= dout[2:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_scope_acq.sv
// Randomised scoreboard bench for scope_acq: host byte traffic checked by a
// monitor process against a sample-list model of the acquisition.
module tb_scope_acq;
  localparam int NSIG = 8, NSAMP = 3, NTIME = 7;
  localparam int D = 1 << NSAMP, NB = 2, RB = D * NB;

  logic            clk = 0, rst_n = 0, select = 0, drequest = 0;
  logic [NSIG-1:0] sig = '0;
  logic [7:0]      dout = '0;
  logic [7:0]      din;

  scope_acq #(.NSIG(NSIG), .NSAMP(NSAMP), .NTIME(NTIME)) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .select(select),
    .dout(dout), .drequest(drequest), .din(din)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [8:0] exp_q[$];
  string      nm_q[$];
  logic       took;
  logic [8:0] e;
  string      n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit c, input logic [7:0] ex,
                      input string name, output logic [7:0] got);
    exp_q.push_back({c, ex});
    nm_q.push_back(name);
    @(posedge clk); #1 dout = b; drequest = 1;
    @(posedge clk); #1 drequest = 0;
    got = din;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] ex, input string name);
    logic [7:0] g;
    xfer(b, 1'b1, ex, name, g);
  endtask

  task automatic poll(input logic [7:0] b, output logic [7:0] got);
    xfer(b, 1'b0, 8'h00, "", got);
  endtask

  task automatic bx(); @(posedge clk); #1 select = 1; endtask
  task automatic ex(); @(posedge clk); #1 select = 0; endtask

  // first sample index at which the trigger fires when sampling the counter
  // source (one sample per clock, values 0,1,2,...), or -1 if never
  function automatic int find_fire(input logic [3*NSIG-1:0] tc, input int np);
    int v, pv;
    bit any, ok;
    for (int k = 0; k < 600; k++) begin
      v  = k % (1 << NSIG);
      pv = (k == 0) ? 0 : (k - 1) % (1 << NSIG);
      any = 0; ok = 1;
      for (int c = 0; c < NSIG; c++) begin
        if (tc[3*c+1]) begin
          any = 1;
          if (((v >> c) & 1) != tc[3*c]) ok = 0;
          if (tc[3*c+2] && ((pv >> c) & 1) == tc[3*c]) ok = 0;
        end
      end
      if (any && ok && k + 1 >= D - np) return k;
    end
    return -1;
  endfunction

  task automatic run_round(input logic [3*NSIG-1:0] tc, input int np_raw, input bit directed);
    int np, k, total, t0, idx;
    logic [7:0] got, b;
    np = (np_raw > D - 1) ? D - 1 : np_raw;
    bx(); send(8'h31, 8'h00, "src_cmd"); ex();
    for (int c = 0; c < NSIG; c++) begin
      b = directed ? 8'h00 : 8'($urandom_range(0, 31) << 3);
      bx(); send(8'h40 | 8'(c), 8'h00, "trig_cmd"); send(b | 8'(tc[3*c +: 3]), 8'h00, "trig_arg"); ex();
    end
    bx(); send(8'h15, 8'h00, "npost_cmd"); send(8'(np_raw), 8'h00, "npost_arg"); ex();
    check("trig_conf", dut.trig_conf, tc);
    check("npost", dut.npost, np);
    k = find_fire(tc, np);
    t0 = cyc;
    bx(); send(8'h28, 8'h00, "restart_cmd"); ex();
    bx(); poll(8'h14, got);
    for (int i = 0; i < 300 && !got[2]; i++) poll(8'h00, got);
    check("done_seen", got[2], k >= 0);
    if (directed) check("done_in_time", (cyc - t0) <= (1 << NTIME), 1);
    send(8'h00, (k >= 0) ? 8'h07 : 8'h01, "sts_more");
    send(8'h00, (k >= 0) ? 8'h07 : 8'h01, "sts_more2");
    ex();
    if (k >= 0) begin
      total = k + np + 1;
      bx();
      for (int j = 0; j < RB + 2; j++) begin
        idx = total - D + j / NB;
        if (j >= RB)          b = 8'h00;
        else if (j % NB == 0) b = 8'(idx % (1 << NSIG));
        else                  b = (idx == 0) ? 8'h00 : 8'h01;
        send((j == 0) ? 8'h16 : 8'h00, b, "readout");
      end
      ex();
    end
  endtask

  initial begin
    logic [3*NSIG-1:0] tc;
    logic [7:0] c, r;
    fork
      forever begin
        @(posedge clk); took = drequest;
        @(negedge clk);
        if (took) begin
          if (exp_q.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (e[8]) check(n, din, e[7:0]);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_din", din, 8'h00);
    check("rst_trig", dut.trig_conf, 0);
    bx(); send(8'h14, 8'h00, "sts_after_rst"); ex();
    bx(); send(8'h11, 8'h53, "id"); ex();
    bx(); send(8'h12, 8'h78, "insp"); ex();
    bx(); send(8'h13, 8'h03, "mem"); ex();
    bx(); send(8'h28, 8'h00, "restart_cmd"); ex();
    bx(); send(8'h14, 8'h00, "sts_after_restart"); ex();

    // random single-byte commands with no side effects
    for (int i = 0; i < 12; i++) begin
      do c = 8'($urandom_range(0, 255));
      while (!(c inside {8'h11, 8'h12, 8'h13} || c < 8'h10 || c >= 8'h50 ||
               (c >= 8'h17 && c <= 8'h27)));
      r = (c == 8'h11) ? 8'h53 : (c == 8'h12) ? 8'h78 : (c == 8'h13) ? 8'h03 : 8'h00;
      bx(); send(c, r, "rand_cmd"); ex();
    end

    // aborted argument, then the next byte must be a fresh command
    bx(); send(8'h15, 8'h00, "npost_cmd"); ex();
    bx(); send(8'h11, 8'h53, "abort_then_id"); ex();
    check("abort_npost", dut.npost, 0);

    tc = '0;
    for (int i = 0; i < NSIG; i++) tc[3*i +: 3] = (i == 0 || i == 2) ? 3'b011 : 3'b010;
    run_round(tc, 2, 1'b1);
    bx(); send(8'h4f, 8'h00, "trig_hi_cmd"); send(8'h07, 8'h00, "trig_hi_arg"); ex();
    check("trig_hi_ignored", dut.trig_conf, tc);
    run_round('0, 3, 1'b0);
    for (int rnd = 0; rnd < 6; rnd++) begin
      sig = NSIG'($urandom);
      for (int i = 0; i < NSIG; i++)
        tc[3*i +: 3] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      run_round(tc, $urandom_range(0, 12), 1'b0);
    end

    // reset in the middle of the post-trigger phase
    @(posedge clk); #1 rst_n = 0; sig = '1;
    @(posedge clk); #1 rst_n = 1;
    bx(); send(8'h40, 8'h00, "trig_cmd"); send(8'h03, 8'h00, "trig_arg"); ex();
    bx(); send(8'h15, 8'h00, "npost_cmd"); send(8'h07, 8'h00, "npost_arg"); ex();
    bx(); send(8'h28, 8'h00, "restart_cmd"); ex();
    repeat (10) @(posedge clk);
    bx(); send(8'h14, 8'h03, "sts_post"); ex();
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 check("midpost_status", {dut.done, dut.triggered, dut.ready}, 0);
    check("midpost_trig", dut.trig_conf, 0);
    check("midpost_din", din, 8'h00);
    @(posedge clk); #1 rst_n = 1;
    repeat (4) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scope_acq.md
SCOPE_ACQ -- requirements
Module: scope_acq

Interface
REQ-001 Parameter NSIG, default 8, number of input signals (1..15).
REQ-002 Parameter NSAMP, default 3, log2 of buffer depth (depth 2**NSAMP samples).
REQ-003 Parameter NTIME, default 7, timestamp field width (1..15).
REQ-004 Derived constants SHALL be NBYTES = ceil((NSIG+NTIME)/8) and NBITS = 8*NBYTES; defaults give 2 and 16.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 sig  input  NSIG  external signals to acquire.
REQ-008 select  input  1  high frames one host transaction; low aborts the transaction.
REQ-009 dout  input  8  host-to-DUT byte.
REQ-010 drequest  input  1  one-cycle strobe; dout is consumed on that edge.
REQ-011 din  output  8  DUT-to-host response byte.

Function
REQ-012 The first strobed byte after select rises SHALL be the command; later bytes in the same transaction are arguments or readout.
REQ-013 din SHALL update on the edge after the drequest cycle and hold until the next strobe.
REQ-014 Command 0x11 ID SHALL return 0x53.
REQ-015 Command 0x12 INSP SHALL return {NTIME[3:0], NSIG[3:0]}.
REQ-016 Command 0x13 MEM SHALL return NSAMP.
REQ-017 Command 0x14 STS SHALL return {5'b0, done, triggered, ready}; each further byte SHALL return the current status.
REQ-018 Command 0x15 SHALL load the next byte into npost, the post-trigger sample count (clipped to 2**NSAMP-1).
REQ-019 Command 0x4c (c = 0..NSIG-1) SHALL load bits [2:0] of the next byte into trig_conf[3c +: 3]; c >= NSIG is ignored.
REQ-020 trig_conf field encoding: bit1 = enable, bit0 = value, bit2 = edge mode.
- Level mode (bit2=0): match when sig equals bit0.
- Edge mode (bit2=1): match on transition to bit0.
REQ-021 Command 0x3s SHALL set the source: s[0]=1 selects the internal test counter (NSIG-bit, +1 per clk); s[0]=0 selects sig.
REQ-022 Command 0x2x with x[3]=1 SHALL restart acquisition on the following edge.
- Restart clears buffer pointers and all status bits, and clears and restarts the test counter.
- It preserves trig_conf, npost and the source selection.
REQ-023 Command 0x16 SHALL stream the buffer, oldest sample first, NBYTES per sample, least-significant byte first; reads past the end return 0x00.
REQ-024 Unknown commands SHALL return 0x00 and take no action.
REQ-025 Sample word SHALL be {time[NTIME-1:0], source[NSIG-1:0]}, zero-padded to NBITS.
- time is the clk count since the previous sample.
- A sample is written when the source changes, or when time saturates at 2**NTIME-1.
REQ-026 Acquisition states:
- ARMED: circular writes; ready=1 once at least (2**NSAMP - npost) samples are written.
- ARMED to POST: when ready and all enabled channels match; triggered=1; the trigger sample is written.
- POST: writes npost further samples.
- DONE: done=1; writes stop; remains here until restart or reset.
REQ-027 A trigger condition with no enabled channel SHALL never fire.
REQ-028 select low mid-transaction SHALL discard partial argument state.

Reset
REQ-029 rst_n low SHALL asynchronously force the following:
- din=0, trig_conf=0, npost=0, source=sig;
- status=0, state ARMED, buffer pointers 0, transaction idle.

Verification
REQ-030 Command 0x11 -> din 0x53; 0x12 -> din 0x78; 0x13 -> din 0x03 (defaults).
REQ-031 After rst_n or 0x28 with source sig, immediate 0x14 -> din 0x00.
REQ-032 Configure triggers 0x40/03, 0x41/02, 0x42/03, 0x43..0x47/02:
- trig_conf fields read 011, 010, 011, 010, 010, 010, 010, 010.
- Command 0x15/02 -> npost=2.
REQ-033 Issue 0x31 then 0x28:
- done rises within 2**NTIME cycles.
- 0x14 -> 0x07; each further byte -> 0x07.
REQ-034 With the REQ-033 setup, 0x16 readout:
- Yields 8 samples (16 bytes).
- Signal bytes are consecutive counter values including 0x05; exactly 2 samples follow 0x05.
REQ-035 Assert rst_n mid-POST -> all status 0 and trig_conf 0 immediately.
